// File: rtl/dcache_write_buffer_pkg.sv
// Shared types and helpers for the D-cache victim write buffer.
package dcache_write_buffer_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_REQ  = 2'd1,
    WB_WAIT = 2'd2
  } wb_state_t;

  // Byte-offset bits inside one cache line.
  function automatic int unsigned wb_offset_w(input int unsigned line_word);
    return $clog2(line_word * 4);
  endfunction

endpackage

// File: rtl/dcache_write_buffer_match_unit.sv
// DEPTH-way line-tag compare with youngest-first priority select.
module dcache_write_buffer_match_unit
  import dcache_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 28,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [TAG_W-1:0] tags [DEPTH],
  input  logic [TAG_W-1:0] query,
  input  logic [PTR_W-1:0] tail,
  output logic             hit,
  output logic [PTR_W-1:0] index
);

  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    idx   = '0;
    for (int k = DEPTH; k > 0; k--) begin
      idx = tail - PTR_W'(k);
      if (valid[idx] && (tags[idx] == query)) begin
        hit   = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/dcache_write_buffer.sv
// In-order FIFO of dirty victim lines draining to the AXI DBus write channel,
// with youngest-wins line forwarding for refills.
// Optional feature: define DCACHE_WB_MERGE_EN to merge pushes into matching
// entries that have not yet been issued to the bus.
module dcache_write_buffer
  import dcache_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LINE_WORD = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic [ADDR_W-1:0]           push_addr,
  input  logic [LINE_WORD*WORD_W-1:0] push_data,
  input  logic [ADDR_W-1:0]           lookup_addr,
  output logic                        lookup_hit,
  output logic [LINE_WORD*WORD_W-1:0] lookup_data,
  output logic                        empty,
  output logic                        wr_req,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [LINE_WORD*WORD_W-1:0] wr_data,
  input  logic                        wr_rdy,
  input  logic                        wr_valid
);

  localparam int unsigned OFFSET_W = wb_offset_w(LINE_WORD);
  localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned LINE_W   = LINE_WORD * WORD_W;

  wb_state_t        state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];

  logic             full;
  logic             push_fire;
  logic             alloc;
  logic             pop;
  logic             merge_wr;
  logic [PTR_W-1:0] merge_idx;
  logic             look_hit;
  logic [PTR_W-1:0] look_idx;
  logic [TAG_W-1:0] push_tag;
  logic [TAG_W-1:0] look_tag;
  logic             unused_offset_bits;

  assign push_tag  = push_addr[ADDR_W-1:OFFSET_W];
  assign look_tag  = lookup_addr[ADDR_W-1:OFFSET_W];
  assign unused_offset_bits = ^{push_addr[OFFSET_W-1:0], lookup_addr[OFFSET_W-1:0]};

  assign full      = (count == CNT_W'(DEPTH));
  assign push_fire = push_valid && push_ready;
  assign pop       = (state == WB_WAIT) && wr_valid;

`ifdef DCACHE_WB_MERGE_EN
  logic [DEPTH-1:0] issued;
  logic [DEPTH-1:0] merge_mask;
  logic             merge_hit;

  // The head is on the bus once the drain FSM leaves IDLE; never merge into it.
  assign issued     = (state != WB_IDLE) ? (DEPTH'(1) << head) : '0;
  assign merge_mask = valid & ~issued;

  dcache_write_buffer_match_unit #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_merge_match (
    .valid (merge_mask),
    .tags  (tag_q),
    .query (push_tag),
    .tail  (tail),
    .hit   (merge_hit),
    .index (merge_idx)
  );

  assign push_ready = !full || merge_hit;
  assign alloc      = push_fire && !merge_hit;
  assign merge_wr   = push_fire && merge_hit;
`else
  assign push_ready = !full;
  assign alloc      = push_fire;
  assign merge_wr   = 1'b0;
  assign merge_idx  = '0;
`endif

  dcache_write_buffer_match_unit #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_lookup_match (
    .valid (valid),
    .tags  (tag_q),
    .query (look_tag),
    .tail  (tail),
    .hit   (look_hit),
    .index (look_idx)
  );

  assign lookup_hit  = look_hit;
  assign lookup_data = look_hit ? data_q[look_idx] : '0;
  assign empty       = (count == '0) && (state == WB_IDLE);
  assign wr_addr     = {tag_q[head], {OFFSET_W{1'b0}}};
  assign wr_data     = data_q[head];

  // Line storage: allocate at tail, or overwrite a merged entry in place.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[tail]  <= push_tag;
      data_q[tail] <= push_data;
    end
    if (merge_wr) begin
      data_q[merge_idx] <= push_data;
    end
  end

  // FIFO pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      unique case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: one line outstanding on the bus at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WB_IDLE;
      wr_req <= 1'b0;
    end else begin
      unique case (state)
        WB_IDLE: begin
          if (count != '0) begin
            state  <= WB_REQ;
            wr_req <= 1'b1;
          end
        end
        WB_REQ: begin
          if (wr_rdy) begin
            state  <= WB_WAIT;
            wr_req <= 1'b0;
          end
        end
        WB_WAIT: begin
          if (wr_valid) begin
            state <= WB_IDLE;
          end
        end
        default: begin
          state  <= WB_IDLE;
          wr_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
